mips_run_monitor: RTL and testbench

Synthesisable run-control and self-check harness for the 32-bit single-cycle MIPS core. It supersedes the fixed-delay reset and fixed-runtime stimulus used in simulation so the same run can execute on silicon or FPGA. The block holds the core in reset for a programmable number of cycles, releases it, and logs every change on the core's `testOut` bus into a small history buffer. It ends the run on a match against an expected value or on a cycle timeout, and reports pass/timeout status.

---
 rtl/mips_run_monitor.sv | 144 ++++++++++++++
 tb/tb_mips_run_monitor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_monitor.sv
// Run-control and self-check harness for the single-cycle MIPS core.
// Holds the core in reset for HOLD_CYCLES after start, then runs it. Every
// change on the core's test bus is logged into a small history buffer. The
// run ends on a match against expect_value or after MAX_CYCLES RUN cycles.
module mips_run_monitor #(
  parameter int DATA_WIDTH  = 32,
  parameter int CNT_W       = 16,
  parameter int MAX_CYCLES  = 30,
  parameter int HOLD_CYCLES = 3,
  parameter int LOG_AW      = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] test_in,
  input  logic [DATA_WIDTH-1:0] expect_value,
  output logic                  core_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [LOG_AW:0]       log_count,
  output logic                  log_overflow,
  input  logic [LOG_AW-1:0]     log_rd_addr,
  output logic [DATA_WIDTH-1:0] log_rd_data
);

  localparam int DEPTH  = 1 << LOG_AW;
  localparam int LCNT_W = LOG_AW + 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [LOG_AW:0]   LOG_FULL   = LCNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CYCLE_LAST = CNT_W'(MAX_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                  state;
  logic [HOLD_W-1:0]       hold_cnt;
  logic [DATA_WIDTH-1:0]   prev;
  logic                    prev_valid;
  logic [DATA_WIDTH-1:0]   log_mem [DEPTH];

  logic                    changed;
  logic                    log_full;
  logic                    log_we;
  logic                    is_match;
  logic [CNT_W-1:0]        cycle_next;
  logic                    is_last_cycle;

  // Per-edge RUN decisions: change detection, log space, match and timeout.
  always_comb begin
    changed       = !prev_valid || (test_in != prev);
    log_full      = (log_count == LOG_FULL);
    log_we        = (state == ST_RUN) && changed && !log_full;
    is_match      = (test_in == expect_value);
    cycle_next    = cycle_count + 1'b1;
    is_last_cycle = (cycle_next == CYCLE_LAST);
  end

  // Run-control FSM with registered status, counters and change tracking.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block sees the pre-edge values of its neighbours.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= ST_IDLE;
      hold_cnt     <= '0;
      prev         <= '0;
      prev_valid   <= 1'b0;
      core_rst_n   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      cycle_count  <= '0;
      log_count    <= '0;
      log_overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state        <= ST_HOLD;
            hold_cnt     <= '0;
            prev_valid   <= 1'b0;
            core_rst_n   <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            cycle_count  <= '0;
            log_count    <= '0;
            log_overflow <= 1'b0;
          end
        end

        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state       <= ST_RUN;
            core_rst_n  <= 1'b1;
            cycle_count <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        ST_RUN: begin
          if (changed) begin
            if (log_full) log_overflow <= 1'b1;
            else          log_count    <= log_count + 1'b1;
          end
          prev        <= test_in;
          prev_valid  <= 1'b1;
          cycle_count <= cycle_next;
          if (is_match || is_last_cycle) begin
            state      <= ST_DONE;
            core_rst_n <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            pass       <= is_match;
            timeout    <= !is_match;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // History buffer write port; contents survive restarts.
  // NOTE: the log array has no reset so it maps onto plain RAM; only the
  // log_count pointer decides which entries are meaningful.
  always_ff @(posedge CLK) begin
    if (log_we) log_mem[log_count[LOG_AW-1:0]] <= test_in;
  end

  assign log_rd_data = log_mem[log_rd_addr];

endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed self-checking bench for mips_run_monitor with default parameters.
module tb_mips_run_monitor;

  localparam int DW  = 32;
  localparam int CW  = 16;
  localparam int MAXC = 30;
  localparam int HOLD = 3;
  localparam int LAW = 3;

  logic          CLK;
  logic          RST;
  logic          start;
  logic [DW-1:0] test_in;
  logic [DW-1:0] expect_value;
  logic          core_rst_n;
  logic          busy;
  logic          done;
  logic          pass;
  logic          timeout;
  logic [CW-1:0] cycle_count;
  logic [LAW:0]  log_count;
  logic          log_overflow;
  logic [LAW-1:0] log_rd_addr;
  logic [DW-1:0] log_rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  mips_run_monitor #(
    .DATA_WIDTH (DW),
    .CNT_W      (CW),
    .MAX_CYCLES (MAXC),
    .HOLD_CYCLES(HOLD),
    .LOG_AW     (LAW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .test_in     (test_in),
    .expect_value(expect_value),
    .core_rst_n  (core_rst_n),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .timeout     (timeout),
    .cycle_count (cycle_count),
    .log_count   (log_count),
    .log_overflow(log_overflow),
    .log_rd_addr (log_rd_addr),
    .log_rd_data (log_rd_data)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One active edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Start edge plus HOLD edges; returns with the FSM in RUN.
  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_clears_log_count", log_count, 0);
    check("start_clears_done", done, 0);
    check("start_busy", busy, 1);
    repeat (HOLD) step();
  endtask

  task automatic check_log(input int addr, input logic [DW-1:0] exp);
    log_rd_addr = LAW'(addr);
    #1;
    check($sformatf("log[%0d]", addr), log_rd_data, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_core_rst_n"}, core_rst_n, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_cycle_count"}, cycle_count, 0);
    check({tag, "_log_count"}, log_count, 0);
    check({tag, "_log_overflow"}, log_overflow, 0);
  endtask

  initial begin
    logic [DW-1:0] seq2 [5];
    seq2 = '{32'd0, 32'd0, 32'd7, 32'd7, 32'd9};

    RST = 1'b0;
    start = 1'b0;
    test_in = '0;
    expect_value = '0;
    log_rd_addr = '0;
    #12;
    check_idle_outputs("reset");
    RST = 1'b1;
    step();

    // --- Test 1: immediate match, latency of core reset release.
    test_in = 32'd5;
    expect_value = 32'd5;
    start = 1'b1;
    step();                       // edge 1: IDLE -> HOLD
    start = 1'b0;
    check("t1_hold_core_rst_n", core_rst_n, 0);
    step();
    step();                       // edge 3
    check("t1_edge3_core_rst_n", core_rst_n, 0);
    step();                       // edge 4: enters RUN
    check("t1_edge4_core_rst_n", core_rst_n, 1);
    check("t1_run_busy", busy, 1);
    step();                       // first RUN sample: match
    check("t1_done", done, 1);
    check("t1_pass", pass, 1);
    check("t1_timeout", timeout, 0);
    check("t1_cycle_count", cycle_count, 1);
    check("t1_log_count", log_count, 1);
    check("t1_core_rst_n_done", core_rst_n, 0);
    check("t1_busy_done", busy, 0);
    check_log(0, 32'd5);

    // --- Test 2: restart from DONE, duplicate suppression in the log.
    expect_value = 32'd9;
    test_in = 32'd0;
    start_run();
    for (int i = 0; i < 5; i++) begin
      test_in = seq2[i];
      step();
      if (i < 4) check($sformatf("t2_not_done_%0d", i), done, 0);
    end
    check("t2_pass", pass, 1);
    check("t2_timeout", timeout, 0);
    check("t2_cycle_count", cycle_count, 5);
    check("t2_log_count", log_count, 3);
    check("t2_overflow", log_overflow, 0);
    check_log(0, 32'd0);
    check_log(1, 32'd7);
    check_log(2, 32'd9);

    // --- Test 3: log overflow followed by timeout.
    expect_value = 32'hDEAD_BEEF;
    start_run();
    for (int i = 1; i <= MAXC; i++) begin
      test_in = (i <= 12) ? DW'(100 + i - 1) : 32'd111;
      step();
      if (i == 8) begin
        check("t3_log_count_8", log_count, 8);
        check("t3_no_overflow_yet", log_overflow, 0);
      end
      if (i == 12) begin
        check("t3_log_count_sat", log_count, 8);
        check("t3_overflow", log_overflow, 1);
      end
      if (i == MAXC - 1) check("t3_not_done_29", done, 0);
    end
    check("t3_done", done, 1);
    check("t3_timeout", timeout, 1);
    check("t3_pass", pass, 0);
    check("t3_cycle_count", cycle_count, MAXC);
    check("t3_log_count_final", log_count, 8);
    for (int a = 0; a < 8; a++) check_log(a, DW'(100 + a));

    // --- Test 4: match on the timeout edge wins.
    expect_value = 32'd77;
    start_run();
    check("t4_overflow_cleared", log_overflow, 0);
    for (int i = 1; i <= MAXC; i++) begin
      test_in = (i == MAXC) ? 32'd77 : 32'd1;
      step();
    end
    check("t4_pass", pass, 1);
    check("t4_timeout", timeout, 0);
    check("t4_cycle_count", cycle_count, MAXC);
    check("t4_log_count", log_count, 2);
    check_log(1, 32'd77);

    // --- Test 5: start ignored in HOLD/RUN, async reset mid-RUN.
    expect_value = 32'd3;
    test_in = 32'd1;
    start = 1'b1;
    step();                       // enter HOLD
    repeat (HOLD + 3) step();     // start held through HOLD and 3 RUN edges
    check("t5_busy", busy, 1);
    check("t5_core_rst_n", core_rst_n, 1);
    check("t5_cycle_count", cycle_count, 3);
    check("t5_log_count", log_count, 1);
    start = 1'b0;
    #2;
    RST = 1'b0;
    #1;
    check_idle_outputs("t5_async_rst");
    step();
    RST = 1'b1;
    step();
    check("t5_idle_after_rst", busy, 0);

    // --- Test 6: a fresh run after reset still works end to end.
    expect_value = 32'd4;
    start_run();
    test_in = 32'd2;
    step();
    test_in = 32'd4;
    step();
    check("t6_pass", pass, 1);
    check("t6_cycle_count", cycle_count, 2);
    check("t6_log_count", log_count, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
